// File: rtl/thread_bundle_queue.sv
// Fetch-to-thread demux: steers each instruction bundle into a per-thread FWFT FIFO
// by thread ID. Provides ready/valid backpressure, per-thread flush and occupancy counts.
module thread_bundle_queue #(
  parameter int NUM_THREADS = 4,
  parameter int LANES       = 4,
  parameter int ISN_WIDTH   = 99,
  parameter int DEPTH       = 4,
  parameter int TID_W       = 2
) (
  input  logic                                       i_Clk,
  input  logic                                       i_Reset,
  input  logic                                       i_Valid,
  input  logic [TID_W-1:0]                           i_Thread,
  input  logic [LANES-1:0]                           i_Lane_Valid,
  input  logic [LANES*ISN_WIDTH-1:0]                 i_Bundle,
  output logic                                       o_Ready,
  output logic                                       o_Drop,
  input  logic [NUM_THREADS-1:0]                     i_Flush,
  input  logic [NUM_THREADS-1:0]                     i_Pop,
  output logic [NUM_THREADS-1:0]                     o_Valid,
  output logic [NUM_THREADS*LANES-1:0]               o_Lane_Valid,
  output logic [NUM_THREADS*LANES*ISN_WIDTH-1:0]     o_Bundle,
  output logic [NUM_THREADS*$clog2(DEPTH+1)-1:0]     o_Count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = LANES * ISN_WIDTH;
  localparam int ENT_W  = LANES + DATA_W;

  logic [NUM_THREADS-1:0] w_sel;
  logic [NUM_THREADS-1:0] w_full;
  logic [NUM_THREADS-1:0] w_push;
  logic [NUM_THREADS-1:0] w_pop;
  logic                   w_tid_ok;
  logic                   w_any_lane;
  logic                   w_drop_next;
  logic                   r_drop;

  // One-hot thread decode; an out-of-range ID simply selects no thread.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : gen_sel
      assign w_sel[gi] = (i_Thread == TID_W'(gi));
    end
  endgenerate

  assign w_tid_ok    = |w_sel;
  assign w_any_lane  = |i_Lane_Valid;
  assign o_Ready     = ~|(w_sel & w_full);
  // Only bundles actually taken from the source can be reported as dropped.
  assign w_drop_next = i_Valid & o_Ready & (~w_tid_ok | ~w_any_lane);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop_next;
    end
  end

  assign o_Drop = r_drop;

  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : gen_thread
      logic [ENT_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr;
      logic [PTR_W-1:0] r_rd;
      logic [CNT_W-1:0] r_cnt;
      logic [ENT_W-1:0] w_head;

      // Full uses the registered count so a same-cycle pop never opens space.
      assign w_full[gi] = (r_cnt == CNT_W'(DEPTH));
      assign w_push[gi] = i_Valid & w_sel[gi] & ~w_full[gi] & w_any_lane & ~i_Flush[gi];
      assign w_pop[gi]  = i_Pop[gi] & (r_cnt != '0) & ~i_Flush[gi];

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          r_wr  <= '0;
          r_rd  <= '0;
          r_cnt <= '0;
        end else if (i_Flush[gi]) begin
          r_wr  <= '0;
          r_rd  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push[gi]) r_wr <= r_wr + 1'b1;
          if (w_pop[gi])  r_rd <= r_rd + 1'b1;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      always_ff @(posedge i_Clk) begin
        if (w_push[gi]) r_mem[r_wr] <= {i_Lane_Valid, i_Bundle};
      end

      assign w_head      = r_mem[r_rd];
      assign o_Valid[gi] = (r_cnt != '0);
      assign o_Lane_Valid[gi*LANES +: LANES] = o_Valid[gi] ? w_head[ENT_W-1 -: LANES] : '0;
      assign o_Bundle[gi*DATA_W +: DATA_W]   = o_Valid[gi] ? w_head[DATA_W-1:0] : '0;
      assign o_Count[gi*CNT_W +: CNT_W]      = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_thread_bundle_queue.sv
// Directed bench for thread_bundle_queue: table of per-cycle vectors plus
// hand sequences for pointer wrap, mid-stream reset and out-of-range thread IDs.
module tb_thread_bundle_queue;

  localparam int LW = 4 * 99;

  typedef struct {
    bit       v;
    bit [1:0] tid;
    bit [3:0] lv;
    bit [7:0] seed;
    bit [3:0] pop;
    bit [3:0] flush;
    bit       rdy;
    bit       drop;
    bit [3:0] valid;
    bit [11:0] cnt;
    bit [1:0] ht;
    bit [7:0] hseed;
    bit [3:0] hl;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [1:0]    i_thread;
  logic [3:0]    i_lane_valid;
  logic [LW-1:0] i_bundle;
  logic [3:0]    i_flush;
  logic [3:0]    i_pop;
  logic          o_ready;
  logic          o_drop;
  logic [3:0]    o_valid;
  logic [15:0]   o_lane_valid;
  logic [4*LW-1:0] o_bundle;
  logic [11:0]   o_count;

  // Second instance with three threads for the out-of-range ID case
  logic          v3;
  logic [1:0]    tid3;
  logic [3:0]    lv3;
  logic [2:0]    flush3;
  logic [2:0]    pop3;
  logic          ready3;
  logic          drop3;
  logic [2:0]    valid3;
  logic [11:0]   lane_valid3;
  logic [3*LW-1:0] bundle3;
  logic [8:0]    count3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thread_bundle_queue u_dut (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(i_valid), .i_Thread(i_thread),
    .i_Lane_Valid(i_lane_valid), .i_Bundle(i_bundle), .o_Ready(o_ready),
    .o_Drop(o_drop), .i_Flush(i_flush), .i_Pop(i_pop), .o_Valid(o_valid),
    .o_Lane_Valid(o_lane_valid), .o_Bundle(o_bundle), .o_Count(o_count)
  );

  thread_bundle_queue #(.NUM_THREADS(3)) u_dut3 (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(v3), .i_Thread(tid3),
    .i_Lane_Valid(lv3), .i_Bundle(i_bundle), .o_Ready(ready3),
    .o_Drop(drop3), .i_Flush(flush3), .i_Pop(pop3), .o_Valid(valid3),
    .o_Lane_Valid(lane_valid3), .o_Bundle(bundle3), .o_Count(count3)
  );

  function automatic logic [LW-1:0] mk(input logic [7:0] s);
    logic [LW-1:0] b;
    logic [98:0]   lane;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      lane        = '0;
      lane[15:0]  = {s, 8'(k)};
      lane[98:91] = s ^ 8'hA5;
      b[k*99 +: 99] = lane;
    end
    return b;
  endfunction

  function automatic bit [11:0] cn(input bit [2:0] c0, input bit [2:0] c1,
                                   input bit [2:0] c2, input bit [2:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    logic [LW-1:0] exp_b;
    logic [3:0]    exp_l;
    @(negedge clk);
    i_valid      = t.v;
    i_thread     = t.tid;
    i_lane_valid = t.lv;
    i_bundle     = mk(t.seed);
    i_pop        = t.pop;
    i_flush      = t.flush;
    #1;
    chk({tag, ".ready"}, LW'(o_ready), LW'(t.rdy));
    @(posedge clk);
    #1;
    exp_b = t.valid[t.ht] ? mk(t.hseed) : '0;
    exp_l = t.valid[t.ht] ? t.hl : 4'h0;
    chk({tag, ".drop"},  LW'(o_drop),  LW'(t.drop));
    chk({tag, ".valid"}, LW'(o_valid), LW'(t.valid));
    chk({tag, ".count"}, LW'(o_count), LW'(t.cnt));
    chk({tag, ".head_lanes"}, LW'(o_lane_valid[t.ht*4 +: 4]), LW'(exp_l));
    chk({tag, ".head_data"},  o_bundle[t.ht*LW +: LW], exp_b);
    $display("%s: v=%0b tid=%0d lv=%b pop=%b flush=%b -> valid=%b count=%h drop=%0b",
             tag, t.v, t.tid, t.lv, t.pop, t.flush, o_valid, o_count, o_drop);
  endtask

  vec_t tbl[20];
  vec_t tv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 4'b1011, 8'h01, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0100, cn(0,0,1,0), 2'd2, 8'h01, 4'b1011};
    tbl[1]  = '{1'b1, 2'd0, 4'hF,    8'h10, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0101, cn(1,0,1,0), 2'd0, 8'h10, 4'hF};
    tbl[2]  = '{1'b1, 2'd0, 4'h1,    8'h11, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0101, cn(2,0,1,0), 2'd0, 8'h10, 4'hF};
    tbl[3]  = '{1'b1, 2'd0, 4'hF,    8'h12, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0101, cn(3,0,1,0), 2'd0, 8'h10, 4'hF};
    tbl[4]  = '{1'b1, 2'd0, 4'hF,    8'h13, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0101, cn(4,0,1,0), 2'd0, 8'h10, 4'hF};
    tbl[5]  = '{1'b1, 2'd0, 4'hF,    8'h14, 4'h0, 4'h0, 1'b0, 1'b0, 4'b0101, cn(4,0,1,0), 2'd0, 8'h10, 4'hF};
    tbl[6]  = '{1'b1, 2'd0, 4'hF,    8'h14, 4'h1, 4'h0, 1'b0, 1'b0, 4'b0101, cn(3,0,1,0), 2'd0, 8'h11, 4'h1};
    tbl[7]  = '{1'b1, 2'd0, 4'hF,    8'h14, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0101, cn(4,0,1,0), 2'd0, 8'h11, 4'h1};
    tbl[8]  = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h1, 4'h0, 1'b1, 1'b0, 4'b0101, cn(3,0,1,0), 2'd0, 8'h12, 4'hF};
    tbl[9]  = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h1, 4'h0, 1'b1, 1'b0, 4'b0101, cn(2,0,1,0), 2'd0, 8'h13, 4'hF};
    tbl[10] = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h1, 4'h0, 1'b1, 1'b0, 4'b0101, cn(1,0,1,0), 2'd0, 8'h14, 4'hF};
    tbl[11] = '{1'b1, 2'd1, 4'hF,    8'h20, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0111, cn(1,1,1,0), 2'd1, 8'h20, 4'hF};
    tbl[12] = '{1'b1, 2'd1, 4'h6,    8'h21, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0111, cn(1,2,1,0), 2'd1, 8'h20, 4'hF};
    tbl[13] = '{1'b1, 2'd3, 4'hF,    8'h30, 4'h0, 4'h0, 1'b1, 1'b0, 4'b1111, cn(1,2,1,1), 2'd3, 8'h30, 4'hF};
    tbl[14] = '{1'b1, 2'd1, 4'hF,    8'h22, 4'h2, 4'h2, 1'b1, 1'b0, 4'b1101, cn(1,0,1,1), 2'd1, 8'h00, 4'h0};
    tbl[15] = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 4'b1101, cn(1,0,1,1), 2'd0, 8'h14, 4'hF};
    tbl[16] = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 4'b1101, cn(1,0,1,1), 2'd3, 8'h30, 4'hF};
    tbl[17] = '{1'b1, 2'd1, 4'h0,    8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 4'b1101, cn(1,0,1,1), 2'd2, 8'h01, 4'b1011};
    tbl[18] = '{1'b0, 2'd2, 4'h0,    8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 4'b1101, cn(1,0,1,1), 2'd2, 8'h01, 4'b1011};
    tbl[19] = '{1'b1, 2'd3, 4'hC,    8'h31, 4'h8, 4'h0, 1'b1, 1'b0, 4'b1101, cn(1,0,1,1), 2'd3, 8'h31, 4'hC};

    rst = 1'b1; i_valid = 1'b0; i_thread = 2'd0; i_lane_valid = 4'h0;
    i_bundle = '0; i_flush = 4'h0; i_pop = 4'h0;
    v3 = 1'b0; tid3 = 2'd0; lv3 = 4'h0; flush3 = 3'h0; pop3 = 3'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", LW'(o_valid), '0);
    chk("reset.count", LW'(o_count), '0);
    chk("reset.drop",  LW'(o_drop),  '0);
    chk("reset.bundle", o_bundle[LW-1:0], '0);
    $display("reset: valid=%b count=%h drop=%0b", o_valid, o_count, o_drop);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range thread ID on the three-thread instance
    @(negedge clk);
    v3 = 1'b1; tid3 = 2'd3; lv3 = 4'hF; i_bundle = mk(8'h77);
    #1 chk("id3.ready", LW'(ready3), LW'(1'b1));
    @(posedge clk); #1;
    chk("id3.drop",  LW'(drop3),  LW'(1'b1));
    chk("id3.count", LW'(count3), '0);
    $display("dut3 push id3: drop=%0b count=%h", drop3, count3);
    @(negedge clk);
    tid3 = 2'd2;
    #1 chk("id2.ready", LW'(ready3), LW'(1'b1));
    @(posedge clk); #1;
    chk("id2.drop",  LW'(drop3),  '0);
    chk("id2.valid", LW'(valid3), LW'(3'b100));
    chk("id2.count", LW'(count3), LW'(9'b001_000_000));
    chk("id2.data",  bundle3[2*LW +: LW], mk(8'h77));
    $display("dut3 push id2: valid=%b count=%h", valid3, count3);
    @(negedge clk);
    v3 = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // DEPTH+3 push/pop pairs on T3 to walk the pointers past the wrap
    for (int i = 0; i < 7; i++) begin
      tv = '{1'b1, 2'd3, 4'hF, 8'(8'h40 + i), 4'h8, 4'h0, 1'b1, 1'b0, 4'b1101,
             cn(1,0,1,1), 2'd3, 8'(8'h40 + i), 4'hF};
      apply(tv, $sformatf("wrap%0d", i));
    end
    tv = '{1'b0, 2'd2, 4'h0, 8'h00, 4'h8, 4'h0, 1'b1, 1'b0, 4'b0101, cn(1,0,1,0), 2'd3, 8'h00, 4'h0};
    apply(tv, "drain3");
    tv = '{1'b1, 2'd1, 4'hF, 8'h60, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0111, cn(1,1,1,0), 2'd1, 8'h60, 4'hF};
    apply(tv, "fill1");
    tv = '{1'b1, 2'd3, 4'h3, 8'h61, 4'h0, 4'h0, 1'b1, 1'b0, 4'b1111, cn(1,1,1,1), 2'd3, 8'h61, 4'h3};
    apply(tv, "fill3");

    // Mid-stream reset with a push, pop and flush pending in the same cycle
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_thread = 2'd0; i_lane_valid = 4'hF;
    i_bundle = mk(8'h70); i_pop = 4'h2; i_flush = 4'h4;
    @(posedge clk); #1;
    chk("midrst.valid",  LW'(o_valid), '0);
    chk("midrst.count",  LW'(o_count), '0);
    chk("midrst.lanes",  LW'(o_lane_valid), '0);
    chk("midrst.drop",   LW'(o_drop), '0);
    for (int t = 0; t < 4; t++) chk($sformatf("midrst.bundle%0d", t), o_bundle[t*LW +: LW], '0);
    $display("mid reset: valid=%b count=%h", o_valid, o_count);
    rst = 1'b0;
    tv = '{1'b1, 2'd0, 4'hF, 8'h50, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0001, cn(1,0,0,0), 2'd0, 8'h50, 4'hF};
    apply(tv, "resume");

    @(negedge clk);
    i_valid = 1'b0; i_pop = 4'h0; i_flush = 4'h0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
